stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   MM:SS.t stopwatch controller. A prescaler divides clk_100MHz down to a
//   0.1 s tick while running. Five BCD digit counters hold the elapsed time.
//   The lap function freezes the displayed time while the counters keep running.
//
// Ports
//   clk_100MHz   in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start_stop   in   1-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear        in   1-cycle pulse: back to IDLE with time zeroed
//   lap          in   1-cycle pulse: freeze/unfreeze the display
//   tick_10Hz    out  1-cycle pulse per counted 0.1 s
//   running      out  high while in RUN
//   lap_frozen   out  high while the display shows the latched lap time
//   d_tenths, d_sec_ones, d_sec_tens, d_min_ones, d_min_tens
//                out  displayed BCD digits (4 bits each)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       tick_10Hz,
    output logic       running,
    output logic       lap_frozen,
    output logic [3:0] d_tenths,
    output logic [3:0] d_sec_ones,
    output logic [3:0] d_sec_tens,
    output logic [3:0] d_min_ones,
    output logic [3:0] d_min_tens
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    localparam logic [23:0] PS_MAX = 24'(TICK_DIV - 1);

    // Digit order: [0]=tenths, [1]=sec_ones, [2]=sec_tens, [3]=min_ones, [4]=min_tens
    localparam logic [4:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9};

    state_t          state_q, state_d;
    logic [23:0]     ps_q, ps_d;
    logic [4:0][3:0] time_q, time_d;
    logic [4:0][3:0] latch_q, latch_d;
    logic [4:0][3:0] disp_q, disp_d;
    logic [4:0][3:0] time_inc;
    logic            frozen_q, frozen_d;
    logic            tick_q, tick_d;
    logic            run_q, run_d;
    logic            tick_now;
    logic            carry;

    // BCD ripple increment; 59:59.9 rolls over to 00:00.0 naturally.
    always_comb begin
        time_inc = time_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            if (carry) begin
                if (time_q[i] == DIGIT_MAX[i]) begin
                    time_inc[i] = '0;
                end else begin
                    time_inc[i] = time_q[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ps_d     = ps_q;
        time_d   = time_q;
        latch_d  = latch_q;
        frozen_d = frozen_q;
        tick_d   = 1'b0;
        tick_now = (state_q == RUN) && (ps_q == PS_MAX);

        if (clear) begin
            state_d  = IDLE;
            ps_d     = '0;
            time_d   = '0;
            latch_d  = '0;
            frozen_d = 1'b0;
        end else begin
            // Counting depends only on the current state, so a tick coinciding
            // with start_stop is still applied before entering PAUSE.
            if (state_q == RUN) begin
                if (tick_now) begin
                    ps_d   = '0;
                    time_d = time_inc;
                    tick_d = 1'b1;
                end else begin
                    ps_d = ps_q + 24'd1;
                end
            end else if (state_q == IDLE) begin
                ps_d = '0;
            end

            if (start_stop) begin
                // A lap in the same cycle is dropped.
                unique case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end else if (lap) begin
                unique case (state_q)
                    RUN: begin
                        if (!frozen_q) begin
                            // time_q is the pre-increment value if a tick lands now.
                            latch_d  = time_q;
                            frozen_d = 1'b1;
                        end else begin
                            frozen_d = 1'b0;
                        end
                    end
                    PAUSE:   frozen_d = 1'b0;
                    default: ;
                endcase
            end
        end

        run_d  = (state_d == RUN);
        // Display register is fed from next-state values so it never lags the counters.
        disp_d = frozen_d ? latch_d : time_d;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ps_q     <= '0;
            time_q   <= '0;
            latch_q  <= '0;
            disp_q   <= '0;
            frozen_q <= 1'b0;
            tick_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            time_q   <= time_d;
            latch_q  <= latch_d;
            disp_q   <= disp_d;
            frozen_q <= frozen_d;
            tick_q   <= tick_d;
            run_q    <= run_d;
        end
    end

    assign tick_10Hz  = tick_q;
    assign running    = run_q;
    assign lap_frozen = frozen_q;
    assign d_tenths   = disp_q[0];
    assign d_sec_ones = disp_q[1];
    assign d_sec_tens = disp_q[2];
    assign d_min_ones = disp_q[3];
    assign d_min_tens = disp_q[4];

endmodule
